// File: rtl/gobang_pkg.sv
// Shared constants and FSM state type for the gobang board painter.
package gobang_pkg;

  localparam int H_RES = 200;
  localparam int CELL  = 10;
  localparam int GRID  = 15;
  localparam int ORG_X = 25;
  localparam int ORG_Y = 0;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] BOARD  = 12'hC84;
  localparam logic [11:0] CURSOR = 12'hF00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last pointer starts at 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last)) grant = 2'b01;
      else if (req[1])                 grant = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

endmodule

// File: rtl/board_cell_painter.sv
// Frame-buffer write scheduler: arbitrates two paint-cell requesters and expands each
// accepted command into CELL*CELL pixel writes in raster order.
module board_cell_painter #(
  parameter int DW    = 15,
  parameter int H_RES = gobang_pkg::H_RES,
  parameter int CELL  = gobang_pkg::CELL,
  parameter int GRID  = gobang_pkg::GRID,
  parameter int ORG_X = gobang_pkg::ORG_X,
  parameter int ORG_Y = gobang_pkg::ORG_Y,
  parameter bit VSYNC = 1'b1
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [3:0]          req0_x,
  input  logic [3:0]          req0_y,
  input  logic [11:0]         req0_rgb,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [3:0]          req1_x,
  input  logic [3:0]          req1_y,
  input  logic [11:0]         req1_rgb,
  input  logic                vblank,
  output logic                we,
  output logic [DW-1:0]       waddr,
  output logic [11:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output gobang_pkg::state_t  dbg_state
);
  import gobang_pkg::*;

  // Handshake: reqN_ready is the combinational grant, only ever high in IDLE; a command
  // transfers on a clock edge where reqN_valid && reqN_ready, and the requester holds its
  // fields stable until that edge.

  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int MAX_ADDR = (ORG_Y + GRID*CELL - 1)*H_RES + ORG_X + GRID*CELL - 1;
  localparam longint ADDR_SPAN = longint'(1) << DW;
  localparam logic [DW-1:0] ROW_STEP = DW'(H_RES - CELL + 1);

  if (longint'(MAX_ADDR) >= ADDR_SPAN) begin : g_addr_check
    $error("board_cell_painter: DW too small for the board footprint");
  end

  state_t          state, state_nx;
  logic [1:0]      grant;
  logic            eligible, accept, bad, last_px, err_q;
  logic [3:0]      sel_x, sel_y;
  logic [11:0]     sel_rgb;
  logic [DW-1:0]   base;
  logic [CW-1:0]   dx, dy;

  assign eligible = (req0_valid | req1_valid) & (!VSYNC | vblank);

  rr_arb2 u_arb (
    .clk   (pclk),
    .rst   (rst),
    .en    ((state == IDLE) & eligible & ~rst),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  always_comb begin
    sel_x   = grant[1] ? req1_x   : req0_x;
    sel_y   = grant[1] ? req1_y   : req0_y;
    sel_rgb = grant[1] ? req1_rgb : req0_rgb;
    bad     = (int'(sel_x) >= GRID) || (int'(sel_y) >= GRID);
    // Only place a multiply appears; the fill loop walks the address incrementally.
    base    = DW'((ORG_Y + int'(sel_y)*CELL)*H_RES + ORG_X + int'(sel_x)*CELL);
  end

  assign last_px = (dx == CW'(CELL-1)) && (dy == CW'(CELL-1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bad ? DONE : FILL;
      FILL:    if (last_px) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      dx    <= '0;
      dy    <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            err_q <= bad;
            wdata <= sel_rgb;
            dx    <= '0;
            dy    <= '0;
            if (!bad) begin
              we    <= 1'b1;
              waddr <= base;
            end
          end
        end
        FILL: begin
          if (last_px) begin
            we <= 1'b0;
          end else if (dx == CW'(CELL-1)) begin
            dx    <= '0;
            dy    <= dy + 1'b1;
            waddr <= waddr + ROW_STEP;
          end else begin
            dx    <= dx + 1'b1;
            waddr <= waddr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign dbg_state = state;

endmodule
